ldl_hs_arbiter: RTL
===================

// Module: ldl_hs_arbiter
// PURPOSE
//  Parametrised successor to the single-channel req/ask/latched/ack latch
//  handshake controller.
//  NCH requesters share one latch bank; a round-robin arbiter grants one at a time.
//  Per grant: assert ask to the latch, wait for latched, then return a 4-phase
//  ack to the granted requester. Adds input synchronisers, a timeout error path
//  and abort handling. Sits between LDL producers and the shared latch stage.
// PARAMETERS
//  NCH          4    number of requester channels (>=1)
//  CW           2    width of ask_sel, clog2(NCH), min 1
//  SYNC_STAGES  2    flops per req/latched synchroniser (>=1)
//  TOUT_W       8    timeout counter width
//  TIMEOUT      200  cycles in ASK before error; 0 disables timeout
// PORTS
//  clk      in   1       clock, rising edge
//  reset    in   1       asynchronous, active-high reset
//  req      in   NCH     per-channel request, level, async to clk
//  ack      out  NCH     per-channel acknowledge, registered, one-hot or zero
//  err      out  NCH     per-channel timeout error, registered, one-hot or zero
//  ask      out  1       latch request to shared latch bank, registered
//  ask_sel  out  CW      index of granted channel; valid while ask=1
//  latched  in   1       latch-done from latch bank, level, async to clk
//  busy     out  1       1 in any state other than IDLE
// BEHAVIOUR
//  Reset: clk and reset are the only clocking/reset inputs; reset is async and active-high.
//   Reset clears all of ack, err, ask, ask_sel, busy, the synchronisers, the timer, the RR pointer (=0) and state (=IDLE).
//   Reset mid-operation aborts immediately; no ack or err is issued.
//  Sync: req_s and latched_s are req and latched delayed by SYNC_STAGES flops.
//   All decisions use only synchronised values.
//  FSM (one-hot or binary, registered outputs):
//   IDLE: if any req_s, grant the lowest index >= ptr, wrapping modulo NCH.
//    Next edge: ask=1, ask_sel=g, timer=0, state ASK.
//   ASK: in priority order:
//    - latched_s=1: ask=0, ack[g]=1, state ACK.
//    - req_s[g]=0 (abort): ask=0, state REL; no ack.
//    - TIMEOUT!=0 and timer==TIMEOUT-1: ask=0, err[g]=1, state ERR.
//    - otherwise timer++ (saturating at all-ones).
//   ACK: when req_s[g]=0 and latched_s=0: ack[g]=0, ptr=(g+1)%NCH, state IDLE.
//   REL: when latched_s=0: ptr=(g+1)%NCH, state IDLE.
//   ERR: when req_s[g]=0: err[g]=0, ptr=(g+1)%NCH, state IDLE.
//    A late latched_s is ignored in ERR.
//  Latency:
//   ask rises SYNC_STAGES+1 edges after the first edge sampling req high (IDLE).
//   ack rises SYNC_STAGES+1 edges after the first edge sampling latched high.
//  Request handling:
//   Requests arriving while busy wait; there is no starvation.
//   After g is served, every other pending channel is served before g again.
//  IDLE is occupied for at least 1 cycle between grants.
//   Back-to-back grants therefore have at least one clean cycle with ask=0.
//  Simultaneous latched_s and req_s[g] fall in ASK: latched wins; ack is still issued.
//  latched_s=1 while in IDLE is ignored.
//   No grant is issued until latched_s=0.
//  ask_sel holds its last value when ask=0. Checkers must compare only while ask=1.
// TESTING
//  1. reset=1, then release; req=4'b0010 -> ask=1 and ask_sel=1 after 3 edges.
//     latched=1 -> ack=4'b0010 after 3 edges. Drop req and latched -> ack=0, busy=0.
//  2. req=4'b1111 held, latch bank answers each ask -> grant order 0,1,2,3,0.
//     Each ack is one-hot.
//  3. TIMEOUT=10, req[2]=1, latched stuck 0 -> ask high for exactly 10 cycles.
//     Then err=4'b0100. Drop req -> err=0, ptr=3.
//  4. Abort: req[0] falls while in ASK -> ask=0 and no ack.
//     latched pulse afterwards -> state returns to IDLE only after latched falls.
//  5. Assert reset while in ACK with ack[1]=1 -> all outputs 0 immediately.
//     ptr=0 after release.
//  6. NCH=1, SYNC_STAGES=1 build: single-channel handshake, ask latency 2 edges.
//     TIMEOUT=0: no err, even after 1000 cycles with latched stuck 0.

Source files
------------

// File: rtl/ldl_hs_arbiter.sv
// Round-robin arbiter sharing one latch bank among NCH requesters.
// Each grant runs ask/latched, then a 4-phase ack; abort and timeout paths included.
module ldl_hs_arbiter #(
    parameter int NCH         = 4,
    parameter int CW          = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TOUT_W      = 8,
    parameter int TIMEOUT     = 200
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] req,
    output logic [NCH-1:0] ack,
    output logic [NCH-1:0] err,
    output logic           ask,
    output logic [CW-1:0]  ask_sel,
    input  logic           latched,
    output logic           busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASK,
        S_ACK,
        S_REL,
        S_ERR
    } state_t;

    localparam int RW = SYNC_STAGES * NCH;
    localparam logic [TOUT_W-1:0] TOUT_LAST = (TIMEOUT == 0) ? '0 : TOUT_W'(TIMEOUT - 1);

    logic [RW-1:0]          req_pipe_q;
    logic [SYNC_STAGES-1:0] lat_pipe_q;
    logic [NCH-1:0]         req_s;
    logic                   lat_s;

    state_t              state_q, state_d;
    logic [CW-1:0]       grant_q, grant_d;
    logic [CW-1:0]       ptr_q, ptr_d;
    logic [TOUT_W-1:0]   timer_q, timer_d;
    logic                ask_q, ask_d;
    logic [NCH-1:0]      ack_q, ack_d;
    logic [NCH-1:0]      err_q, err_d;
    logic                busy_q, busy_d;

    // Oldest sample sits in the top slice of each shift pipe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_pipe_q <= '0;
            lat_pipe_q <= '0;
        end else begin
            req_pipe_q <= (req_pipe_q << NCH) | RW'(req);
            lat_pipe_q <= (lat_pipe_q << 1) | SYNC_STAGES'(latched);
        end
    end

    assign req_s = req_pipe_q[RW-1 -: NCH];
    assign lat_s = lat_pipe_q[SYNC_STAGES-1];

    logic [NCH-1:0] hi_mask;
    logic [NCH-1:0] req_hi;
    logic [NCH-1:0] pick_vec;
    logic [NCH-1:0] pick_onehot;
    logic [CW-1:0]  pick_term [NCH];
    logic [CW-1:0]  pick_or   [NCH+1];
    logic [CW-1:0]  pick_idx;

    // Prefer requesters at or above ptr; otherwise wrap to the lowest index.
    assign req_hi      = req_s & hi_mask;
    assign pick_vec    = (|req_hi) ? req_hi : req_s;
    assign pick_onehot = pick_vec & (~pick_vec + NCH'(1));
    assign pick_or[0]  = '0;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_rr
        assign hi_mask[gi]    = (CW'(gi) >= ptr_q);
        assign pick_term[gi]  = pick_onehot[gi] ? CW'(gi) : '0;
        assign pick_or[gi+1]  = pick_or[gi] | pick_term[gi];
    end

    assign pick_idx = pick_or[NCH];

    logic [NCH-1:0] gmask;
    logic           req_g;
    logic [CW-1:0]  ptr_next;

    assign gmask    = NCH'(1) << grant_q;
    assign req_g    = |(req_s & gmask);
    assign ptr_next = (grant_q == CW'(NCH - 1)) ? '0 : grant_q + CW'(1);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        timer_d = timer_q;
        ask_d   = ask_q;
        ack_d   = ack_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                // A latched level left over from a previous grant blocks new grants.
                if ((|req_s) && !lat_s) begin
                    grant_d = pick_idx;
                    ask_d   = 1'b1;
                    timer_d = '0;
                    state_d = S_ASK;
                end
            end
            S_ASK: begin
                if (lat_s) begin
                    ask_d   = 1'b0;
                    ack_d   = gmask;
                    state_d = S_ACK;
                end else if (!req_g) begin
                    ask_d   = 1'b0;
                    state_d = S_REL;
                end else if ((TIMEOUT != 0) && (timer_q == TOUT_LAST)) begin
                    ask_d   = 1'b0;
                    err_d   = gmask;
                    state_d = S_ERR;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + TOUT_W'(1);
                end
            end
            S_ACK: begin
                if (!req_g && !lat_s) begin
                    ack_d   = '0;
                    ptr_d   = ptr_next;
                    state_d = S_IDLE;
                end
            end
            S_REL: begin
                if (!lat_s) begin
                    ptr_d   = ptr_next;
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                if (!req_g) begin
                    err_d   = '0;
                    ptr_d   = ptr_next;
                    state_d = S_IDLE;
                end
            end
            default: begin
                ask_d   = 1'b0;
                ack_d   = '0;
                err_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            timer_q <= '0;
            ask_q   <= 1'b0;
            ack_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
            ask_q   <= ask_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign ack     = ack_q;
    assign err     = err_q;
    assign ask     = ask_q;
    assign ask_sel = grant_q;
    assign busy    = busy_q;

endmodule
